// File: rtl/fetch_pkg.sv
// fetch_pkg: geometry defaults and shared types for the fetch stage.
// Imported by fetch_unit and fetch_byte_queue.
package fetch_pkg;

    localparam int LINE_BYTES   = 64;
    localparam int WINDOW_BYTES = 15;
    localparam int BUF_BYTES    = 32;

    localparam int LINE_AW = $clog2(LINE_BYTES);
    localparam int BUF_AW  = $clog2(BUF_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    function automatic logic [63:0] line_addr(input logic [63:0] a);
        return a & ~64'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: 32x8 circular byte storage for the fetch stage.
// Ports: clk/reset_n; write port wr_en, wr_base (first slot), wr_count
// (bytes, <= BUF_BYTES), wr_bytes (byte j -> slot wr_base+j);
// read port head -> win, byte k of win = slot (head+k) mod BUF_BYTES.
module fetch_byte_queue
    import fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [BUF_AW-1:0]         wr_base,
    input  logic [BUF_AW:0]           wr_count,
    input  logic [BUF_BYTES*8-1:0]    wr_bytes,
    input  logic [BUF_AW-1:0]         head,
    output logic [0:WINDOW_BYTES*8-1] win
);

    logic [7:0]        mem_q [BUF_BYTES];
    logic [7:0]        mem_d [BUF_BYTES];
    logic [BUF_AW-1:0] rel;

    // Each slot checks whether it lies inside the wrapped write span.
    always_comb begin
        rel = '0;
        for (int s = 0; s < BUF_BYTES; s++) begin
            mem_d[s] = mem_q[s];
            rel      = BUF_AW'(s) - wr_base;
            if (wr_en && ({1'b0, rel} < wr_count)) begin
                mem_d[s] = wr_bytes[{rel, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < BUF_BYTES; s++) begin
                mem_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < BUF_BYTES; s++) begin
                mem_q[s] <= mem_d[s];
            end
        end
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            win[8*k +: 8] = mem_q[head + BUF_AW'(k)];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches I-cache lines into a circular byte queue and
// presents a decode window at decode_rip; set_rip redirects fetch.
// Ports: clk, reset_n, set_rip/new_rip (redirect), icache_enable/
// icache_addr/icache_rdata/icache_done (line fetch), decode_bytes/
// decode_rip/decode_valid (window), decode_ack/bytes_decoded (consume).
module fetch_unit
    import fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      set_rip,
    input  logic [63:0]               new_rip,
    output logic                      icache_enable,
    output logic [63:0]               icache_addr,
    input  logic [LINE_BYTES*8-1:0]   icache_rdata,
    input  logic                      icache_done,
    output logic [0:WINDOW_BYTES*8-1] decode_bytes,
    output logic [63:0]               decode_rip,
    output logic                      decode_valid,
    input  logic                      decode_ack,
    input  logic [7:0]                bytes_decoded
);

    fetch_state_t      state_q, state_d;
    logic [BUF_AW-1:0] head_q, head_d;
    logic [BUF_AW:0]   occ_q, occ_d;
    logic [63:0]       head_rip_q, head_rip_d;
    logic [63:0]       fetch_addr_q, fetch_addr_d;
    logic [63:0]       req_addr_q, req_addr_d;
    logic              rip_ok_q, rip_ok_d;
    logic              req_q, req_d;

    logic [LINE_AW-1:0]     off;
    logic [LINE_AW-1:0]     src;
    logic [LINE_AW:0]       room;
    logic [BUF_AW:0]        free;
    logic [BUF_AW:0]        n;
    logic                   consume;
    logic                   wr_en;
    logic [BUF_BYTES*8-1:0] wr_bytes;

    assign decode_valid = (occ_q >= (BUF_AW+1)'(WINDOW_BYTES))
                          && (state_q != DROP);
    assign consume       = decode_ack && decode_valid;
    assign icache_enable = req_q;
    assign icache_addr   = req_addr_q;
    assign decode_rip    = head_rip_q;

    // Append size: rest of the line from off, capped by free space
    // measured before this cycle's consume.
    always_comb begin
        off  = fetch_addr_q[LINE_AW-1:0];
        room = (LINE_AW+1)'(LINE_BYTES) - {1'b0, off};
        free = (BUF_AW+1)'(BUF_BYTES) - occ_q;
        n    = (room > (LINE_AW+1)'(free)) ? free : room[BUF_AW:0];
    end

    // Gather line bytes starting at off; wrapped bytes beyond n are
    // never written.
    always_comb begin
        src      = '0;
        wr_bytes = '0;
        for (int j = 0; j < BUF_BYTES; j++) begin
            src = off + LINE_AW'(j);
            wr_bytes[8*j +: 8] = icache_rdata[{src, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        occ_d        = occ_q;
        head_rip_d   = head_rip_q;
        fetch_addr_d = fetch_addr_q;
        rip_ok_d     = rip_ok_q;
        req_d        = req_q;
        req_addr_d   = req_addr_q;
        wr_en        = 1'b0;
        if (set_rip) begin
            occ_d        = '0;
            head_rip_d   = new_rip;
            fetch_addr_d = new_rip;
            rip_ok_d     = 1'b1;
            unique case (state_q)
                IDLE: begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    req_addr_d = line_addr(new_rip);
                end
                REQ, DROP: begin
                    // An outstanding line belongs to the old stream.
                    if (icache_done) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rip_ok_q && (free != '0)) begin
                        state_d    = REQ;
                        req_d      = 1'b1;
                        req_addr_d = line_addr(fetch_addr_q);
                    end
                end
                REQ: begin
                    if (icache_done) begin
                        wr_en        = 1'b1;
                        fetch_addr_d = fetch_addr_q + 64'(n);
                        state_d      = IDLE;
                        req_d        = 1'b0;
                    end
                end
                DROP: begin
                    if (icache_done) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
            if (consume) begin
                head_d     = head_q + bytes_decoded[BUF_AW-1:0];
                head_rip_d = head_rip_q + 64'(bytes_decoded);
            end
            occ_d = occ_q
                    - (consume ? bytes_decoded[BUF_AW:0] : '0)
                    + (wr_en ? n : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            head_q       <= '0;
            occ_q        <= '0;
            head_rip_q   <= '0;
            fetch_addr_q <= '0;
            rip_ok_q     <= 1'b0;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            occ_q        <= occ_d;
            head_rip_q   <= head_rip_d;
            fetch_addr_q <= fetch_addr_d;
            rip_ok_q     <= rip_ok_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
        end
    end

    fetch_byte_queue u_queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_base  (head_q + occ_q[BUF_AW-1:0]),
        .wr_count (n),
        .wr_bytes (wr_bytes),
        .head     (head_q),
        .win      (decode_bytes)
    );

    a_bd_max: assert property (@(posedge clk) disable iff (!reset_n)
        (decode_ack && decode_valid)
        |-> (bytes_decoded <= 8'(WINDOW_BYTES)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, reset corner cases and random traffic
// for fetch_unit, checked against a byte-queue reference model.
module tb_fetch_unit;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         set_rip;
    logic [63:0]  new_rip;
    logic         icache_enable;
    logic [63:0]  icache_addr;
    logic [511:0] icache_rdata;
    logic         icache_done;
    logic [0:119] decode_bytes;
    logic [63:0]  decode_rip;
    logic         decode_valid;
    logic         decode_ack;
    logic [7:0]   bytes_decoded;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .set_rip       (set_rip),
        .new_rip       (new_rip),
        .icache_enable (icache_enable),
        .icache_addr   (icache_addr),
        .icache_rdata  (icache_rdata),
        .icache_done   (icache_done),
        .decode_bytes  (decode_bytes),
        .decode_rip    (decode_rip),
        .decode_valid  (decode_valid),
        .decode_ack    (decode_ack),
        .bytes_decoded (bytes_decoded)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queue holds the bytes in program order.
    logic [7:0]  mq[$];
    logic        m_busy;
    logic        m_stale;
    logic        m_seen;
    logic [63:0] m_rip;
    logic [63:0] m_fa;
    logic [63:0] m_addr;

    typedef struct packed {
        logic        s;
        logic [63:0] nr;
        logic        d;
        logic        a;
        logic [7:0]  b;
        logic        en;
        logic [63:0] addr;
        logic        v;
        logic [63:0] rip;
        logic [7:0]  b0;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] memb(input logic [63:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [511:0] line_of(input logic [63:0] base);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = memb(base + 64'(i));
        return r;
    endfunction

    function automatic vec_t mk(
        input logic s, input logic [63:0] nr, input logic d,
        input logic a, input logic [7:0] b, input logic en,
        input logic [63:0] addr, input logic v,
        input logic [63:0] rip, input logic [7:0] b0);
        vec_t r;
        r.s = s; r.nr = nr; r.d = d; r.a = a; r.b = b;
        r.en = en; r.addr = addr; r.v = v; r.rip = rip; r.b0 = b0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [119:0] act,
                       input logic [119:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0; m_stale = 1'b0; m_seen = 1'b0;
        m_rip = '0; m_fa = '0; m_addr = '0;
    endtask

    task automatic model_step(input logic s, input logic [63:0] nr,
                              input logic d, input logic a,
                              input logic [7:0] b);
        int  sz;
        int  off;
        int  n;
        logic dv;
        sz = mq.size();
        dv = (sz >= 15) && !m_stale;
        if (s) begin
            mq.delete();
            m_rip = nr; m_fa = nr; m_seen = 1'b1;
            if (!m_busy) begin
                m_busy = 1'b1;
                m_addr = {nr[63:6], 6'b0};
            end else if (d) begin
                m_busy = 1'b0; m_stale = 1'b0;
            end else begin
                m_stale = 1'b1;
            end
        end else begin
            if (m_busy && d) begin
                if (!m_stale) begin
                    off = int'(m_fa[5:0]);
                    n = (64 - off < 32 - sz) ? 64 - off : 32 - sz;
                    for (int i = 0; i < n; i++) mq.push_back(memb(m_fa + 64'(i)));
                    m_fa = m_fa + 64'(n);
                end
                m_busy = 1'b0; m_stale = 1'b0;
            end else if (!m_busy && m_seen && sz < 32) begin
                m_busy = 1'b1;
                m_addr = {m_fa[63:6], 6'b0};
            end
            if (a && dv) begin
                for (int i = 0; i < int'(b); i++) void'(mq.pop_front());
                m_rip = m_rip + 64'(b);
            end
        end
    endtask

    task automatic check_model();
        logic [0:119] w;
        logic mv;
        mv = (mq.size() >= 15) && !m_stale;
        chk("m_en", 120'(icache_enable), 120'(m_busy));
        chk("m_addr", 120'(icache_addr), 120'(m_addr));
        chk("m_valid", 120'(decode_valid), 120'(mv));
        chk("m_rip", 120'(decode_rip), 120'(m_rip));
        if (mv) begin
            w = '0;
            for (int k = 0; k < 15; k++) w[8*k +: 8] = mq[k];
            chk("m_window", decode_bytes, w);
        end
    endtask

    task automatic cyc(input logic s, input logic [63:0] nr, input logic d,
                       input logic a, input logic [7:0] b);
        @(negedge clk);
        set_rip       = s;
        new_rip       = nr;
        icache_done   = d;
        icache_rdata  = d ? line_of(m_addr) : '0;
        decode_ack    = a;
        bytes_decoded = b;
        @(posedge clk);
        model_step(s, nr, d, a, b);
        #1;
        check_model();
    endtask

    initial begin
        logic [0:119] w;
        logic         s;
        logic         d;
        logic         a;
        logic [7:0]   b;
        logic [63:0]  nr;

        reset_n = 1'b0;
        set_rip = 1'b0; new_rip = '0; icache_done = 1'b0;
        icache_rdata = '0; decode_ack = 1'b0; bytes_decoded = '0;
        model_reset();
        #1;
        chk("rst_en", 120'(icache_enable), 120'(0));
        chk("rst_addr", 120'(icache_addr), 120'(0));
        chk("rst_valid", 120'(decode_valid), 120'(0));
        chk("rst_rip", 120'(decode_rip), 120'(0));
        chk("rst_bytes", decode_bytes, 120'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 8'd0);
        chk("no_rip_no_fetch", 120'(icache_enable), 120'(0));

        //           s     nr           d     a     b      en    addr         v     rip          b0
        tbl.push_back(mk(1'b1, 64'h400004, 1'b0, 1'b0, 8'd0,  1'b1, 64'h400000, 1'b0, 64'h400004, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h400000, 1'b1, 64'h400004, 8'h04));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b0, 64'h400000, 1'b1, 64'h400004, 8'h04));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd3,  1'b0, 64'h400000, 1'b1, 64'h400007, 8'h07));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b1, 64'h400000, 1'b1, 64'h400007, 8'h07));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h400000, 1'b1, 64'h400007, 8'h07));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd9,  1'b0, 64'h400000, 1'b1, 64'h400010, 8'h10));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b1, 64'h400000, 1'b1, 64'h400010, 8'h10));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b1, 8'd15, 1'b0, 64'h400000, 1'b1, 64'h40001f, 8'h1f));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd1,  1'b1, 64'h400000, 1'b1, 64'h400020, 8'h20));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h400000, 1'b1, 64'h400020, 8'h20));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd5,  1'b0, 64'h400000, 1'b1, 64'h400025, 8'h25));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b1, 64'h400040, 1'b1, 64'h400025, 8'h25));
        tbl.push_back(mk(1'b1, 64'h500000, 1'b0, 1'b0, 8'd0,  1'b1, 64'h400040, 1'b0, 64'h500000, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h400040, 1'b0, 64'h500000, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b1, 64'h500000, 1'b0, 64'h500000, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h500000, 1'b1, 64'h500000, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd5,  1'b0, 64'h500000, 1'b1, 64'h500005, 8'h05));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b0, 8'd0,  1'b1, 64'h500000, 1'b1, 64'h500005, 8'h05));
        tbl.push_back(mk(1'b1, 64'h600010, 1'b1, 1'b1, 8'd5,  1'b0, 64'h500000, 1'b0, 64'h600010, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b0, 1'b1, 8'd4,  1'b1, 64'h600000, 1'b0, 64'h600010, 8'h00));
        tbl.push_back(mk(1'b0, 64'h0,      1'b1, 1'b0, 8'd0,  1'b0, 64'h600000, 1'b1, 64'h600010, 8'h10));

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].nr, tbl[i].d, tbl[i].a, tbl[i].b);
            chk($sformatf("t%0d_en", i), 120'(icache_enable), 120'(tbl[i].en));
            chk($sformatf("t%0d_addr", i), 120'(icache_addr), 120'(tbl[i].addr));
            chk($sformatf("t%0d_valid", i), 120'(decode_valid), 120'(tbl[i].v));
            chk($sformatf("t%0d_rip", i), 120'(decode_rip), 120'(tbl[i].rip));
            if (tbl[i].v) begin
                for (int k = 0; k < 15; k++) w[8*k +: 8] = tbl[i].b0 + 8'(k);
                chk($sformatf("t%0d_window", i), decode_bytes, w);
            end
        end

        // Reset while a request is outstanding.
        cyc(1'b0, '0, 1'b0, 1'b1, 8'd5);
        cyc(1'b0, '0, 1'b0, 1'b0, 8'd0);
        chk("pre_rst_en", 120'(icache_enable), 120'(1));
        #2;
        reset_n = 1'b0;
        set_rip = 1'b0; icache_done = 1'b0; decode_ack = 1'b0;
        model_reset();
        #1;
        chk("arst_en", 120'(icache_enable), 120'(0));
        chk("arst_addr", 120'(icache_addr), 120'(0));
        chk("arst_valid", 120'(decode_valid), 120'(0));
        chk("arst_rip", 120'(decode_rip), 120'(0));
        chk("arst_bytes", decode_bytes, 120'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0, 8'd0);
        chk("stray_en", 120'(icache_enable), 120'(0));
        chk("stray_valid", 120'(decode_valid), 120'(0));
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 8'd0);
        chk("post_rst_idle", 120'(icache_enable), 120'(0));

        // Random traffic against the model.
        cyc(1'b1, 64'h0000_0000_0070_0003, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 4000; c++) begin
            s  = ($urandom_range(0, 39) == 0);
            nr = {$urandom, $urandom};
            d  = m_busy && ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 1);
            b  = 8'($urandom_range(1, 15));
            cyc(s, nr, d, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage between the instruction cache and the decoder. It requests 64-byte lines from the I-cache and packs them into a 32-byte circular byte queue. It presents a 15-byte decode window with its RIP, and advances by the byte count the decoder reports consumed. A redirect (`set_rip`) flushes the queue and restarts fetch at the new RIP; a line already in flight is discarded safely.

## Interface
- `LINE_BYTES`, 64: I-cache line size; a power of two.
- `WINDOW_BYTES`, 15: decode window size (maximum x86 instruction length).
- `BUF_BYTES`, 32: queue capacity; a power of two, ≥ `WINDOW_BYTES`+1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `set_rip` in 1: one-cycle redirect pulse.
- `new_rip` in 64: redirect target; sampled when `set_rip`=1.
- `icache_enable` out 1: line request; level signal, held until `icache_done`.
- `icache_addr` out 64: line-aligned request address; `[5:0]`=0.
- `icache_rdata` in 512: line data; byte i is at bits `[8i+7:8i]`.
- `icache_done` in 1: one-cycle pulse; `icache_rdata` is valid in that cycle.
- `decode_bytes` out 120 (`[0:119]`): window; byte 0 (at RIP) is at bits `[0:7]`.
- `decode_rip` out 64: address of window byte 0.
- `decode_valid` out 1: the window holds ≥ `WINDOW_BYTES` valid bytes.
- `decode_ack` in 1: the decoder consumed `bytes_decoded` bytes this cycle.
- `bytes_decoded` in 8: consumed count, 1..15.

## Operation
- State: `head` (5b), `occ` (6b, range 0..32), `head_rip` (64b), `fetch_addr` (64b), FSM {IDLE, REQ, DROP}.
- Reset: FSM=IDLE, `occ`=0, `head`=0, `head_rip`=0, `fetch_addr`=0.
  - Reset values of outputs: `icache_enable`=0, `icache_addr`=0, `decode_valid`=0, `decode_bytes`=0, `decode_rip`=0.
  - No fetch starts until the first `set_rip`.
- IDLE → REQ when free = 32−`occ` > 0 and `fetch_addr` is valid (any `set_rip` seen since reset).
  - On entry: `icache_addr` ← {`fetch_addr[63:6]`, 6'b0}, `icache_enable` ← 1.
- REQ, `icache_done`=1:
  - off = `fetch_addr[5:0]`.
  - n = min(64−off, free), with free taken before this cycle's consume.
  - Line bytes off..off+n−1 are written at queue slots (`head`+`occ`) mod 32 onward.
  - `fetch_addr` += n.
  - `icache_enable` ← 0; FSM → IDLE. A partially consumed line is re-requested later.
- Consume: when `decode_ack`=1 and `decode_valid`=1:
  - `head` += `bytes_decoded` (mod 32).
  - `head_rip` += `bytes_decoded`.
  - `occ` −= `bytes_decoded`.
  - `decode_ack` while `decode_valid`=0 is ignored.
- Same-cycle append and consume: `occ` ← `occ` − consumed + n.
- Redirect (`set_rip`=1) has priority over append and consume:
  - `occ` ← 0; `head_rip` ← `new_rip`; `fetch_addr` ← `new_rip`.
  - From IDLE: → REQ next cycle.
  - From REQ with `icache_done`=0: → DROP. `icache_enable` stays 1 with the old address.
  - From REQ or DROP with `icache_done`=1: the data is discarded; → IDLE.
  - DROP, `icache_done`=1: discard; → IDLE.
- `decode_valid` = (`occ` ≥ 15) and not DROP-pending-flush. `decode_bytes` byte k = queue[(`head`+k) mod 32]. `decode_rip` = `head_rip`.
- Assertion: `bytes_decoded` ≤ 15 whenever acked.

## Timing
- `set_rip` at cycle t → `icache_enable`=1 at t+1, with `icache_addr` = line of `new_rip`.
- `icache_done` at t+k → bytes visible in the window at t+k+1. `icache_enable`=0 at t+k+1; next request at t+k+2 at the earliest.
- The window outputs are registered and reflect a consume one cycle after `decode_ack`.
- During and after a redirect cycle, `decode_valid`=0 until refill.
- Async reset takes effect mid-request; any later `icache_done` with FSM=IDLE is ignored.

## Structure
- Shared package `fetch_pkg` holds:
  - `LINE_BYTES`, `WINDOW_BYTES`, `BUF_BYTES` defaults.
  - the `fetch_state_t` enum {IDLE, REQ, DROP}.
- Sub-module `fetch_byte_queue` holds the 32×8 storage:
  - multi-byte write port (base slot, count ≤ 32, bytes);
  - 15-byte rotated read window from `head`.
- `fetch_unit` itself owns the FSM, the pointers and the arithmetic.

## Test plan
- Cold start: `set_rip`, `new_rip`=0x400004; done with byte i = i.
  - Request: `icache_addr`=0x400000.
  - After done: `occ`=32, `decode_rip`=0x400004, window bytes 0x04..0x12, `fetch_addr`=0x400024.
- Consume: ack with `bytes_decoded`=3.
  - `decode_rip`=0x400007, window 0x07..0x15, `occ`=29.
  - Next request: addr 0x400000; after done, 3 bytes appended (0x24..0x26).
- Wrap: drain to `occ`=16 with `head` at 28, then append 16 bytes.
  - Window bytes are contiguous across slots 31→0; `occ`=32.
- Redirect mid-flight: `set_rip` (0x500000) while in REQ.
  - `icache_enable` is held; the returning line is discarded; FSM → IDLE.
  - Next request is 0x500000; `decode_valid`=0 until refill.
- Simultaneous append, ack of 5, and `set_rip` in one cycle: the redirect wins, `occ`=0, `head_rip`=`new_rip`.
- Reset asserted in REQ: all outputs go to 0 immediately; a stray `icache_done` is ignored.
